// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with per-register busy scoreboard.
// Optional write-first read forwarding: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    output logic [AW:0]         busy_count
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_en;
    logic             set_busy;
    logic             clr_busy;

    assign wr_en       = we && (wa != '0);
    assign issue_ready = (issue_rd == '0) || !busy[issue_rd]
                       || (we && (wa == issue_rd));
    assign set_busy    = issue_valid && issue_ready && (issue_rd != '0);
    assign clr_busy    = wr_en && busy[wa];

    // Set is applied after clear so a same-register collision stays busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_en) begin
                mem[wa]  <= wd;
                busy[wa] <= 1'b0;
            end
            if (set_busy) begin
                busy[issue_rd] <= 1'b1;
            end
            busy_count <= busy_count + {{AW{1'b0}}, set_busy}
                                     - {{AW{1'b0}}, clr_busy};
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;

        assign a   = ra[k*AW +: AW];
        assign hit = wr_en && (wa == a);

`ifdef REGFILE_BYPASS_EN
        assign rd[k*XLEN +: XLEN] = hit ? wd : mem[a];
`else
        assign rd[k*XLEN +: XLEN] = mem[a];
`endif
        assign rd_busy[k] = busy[a] && !hit;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default 32x32, 2 read ports).
// Expected read data is queued when stimulus is driven and popped on sampling.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                clk;
    logic                rst;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic [AW:0]         busy_count;

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] exp_q [$];

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] e;
        rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
        ra = {5'd0, 5'd3};
        tick();
        idle();
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd[31:0] !== e) begin
            bad++;
            $display("FAIL reset_mem3 got=%h want=%h", rd[31:0], e);
        end
        total++;
        if (rd[63:32] !== 32'h0) begin
            bad++;
            $display("FAIL reset_r0 got=%h want=0", rd[63:32]);
        end
        total++;
        if (rd_busy !== 2'b00) begin
            bad++;
            $display("FAIL reset_busy got=%b want=00", rd_busy);
        end
        total++;
        if (busy_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", busy_count);
        end
    endtask

    task automatic test_write_read();
        logic [XLEN-1:0] e;
        we = 1'b1; wa = 5'd5; wd = 32'h12345678;
        exp_q.push_back(32'h12345678);
        tick();
        idle();
        ra = {5'd0, 5'd5};
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd[31:0] !== e) begin
            bad++;
            $display("FAIL write_read got=%h want=%h", rd[31:0], e);
        end
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        exp_q.push_back(32'h0);
        tick();
        idle();
        ra = {5'd0, 5'd0};
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd[31:0] !== e || rd[63:32] !== e) begin
            bad++;
            $display("FAIL write_r0 got=%h want=%h", rd[31:0], e);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] e;
        ra = {5'd7, 5'd5};
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(32'h0);
`endif
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd[63:32] !== e) begin
            bad++;
            $display("FAIL bypass_same got=%h want=%h", rd[63:32], e);
        end
        exp_q.push_back(32'hA5A5A5A5);
        tick();
        idle();
        #1;
        e = exp_q.pop_front();
        total++;
        if (rd[63:32] !== e) begin
            bad++;
            $display("FAIL bypass_next got=%h want=%h", rd[63:32], e);
        end
    endtask

    task automatic test_scoreboard();
        logic [XLEN-1:0] e;
        int waited;
        ra = {5'd0, 5'd10};
        issue_valid = 1'b1; issue_rd = 5'd10;
        #1;
        total++;
        if (issue_ready !== 1'b1) begin
            bad++;
            $display("FAIL sb_first_ready got=%b want=1", issue_ready);
        end
        tick();
        #1;
        total++;
        if (rd_busy[0] !== 1'b1 || busy_count !== 6'd1) begin
            bad++;
            $display("FAIL sb_busy got=%b/%0d want=1/1",
                     rd_busy[0], busy_count);
        end
        total++;
        if (issue_ready !== 1'b0) begin
            bad++;
            $display("FAIL sb_waw_stall got=%b want=0", issue_ready);
        end
        tick();
        #1;
        total++;
        if (issue_ready !== 1'b0 || busy_count !== 6'd1) begin
            bad++;
            $display("FAIL sb_hold got=%b/%0d want=0/1",
                     issue_ready, busy_count);
        end
        we = 1'b1; wa = 5'd10; wd = 32'hCAFEF00D;
        exp_q.push_back(32'hCAFEF00D);
        #1;
        total++;
        if (issue_ready !== 1'b1 || rd_busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL sb_wb_release got=%b/%b want=1/0",
                     issue_ready, rd_busy[0]);
        end
        tick();
        idle();
        #1;
        e = exp_q.pop_front();
        total++;
        if (busy_count !== 6'd1 || rd_busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL sb_set_wins got=%0d/%b want=1/1",
                     busy_count, rd_busy[0]);
        end
        total++;
        if (rd[31:0] !== e) begin
            bad++;
            $display("FAIL sb_wb_data got=%h want=%h", rd[31:0], e);
        end
        we = 1'b1; wa = 5'd10; wd = 32'h0;
        tick();
        idle();
        waited = 0;
        while (busy_count !== 6'd0 && waited < 8) begin
            tick();
            waited++;
        end
        total++;
        if (busy_count !== 6'd0) begin
            bad++;
            $display("FAIL sb_clear got=%0d want=0", busy_count);
        end
    endtask

    task automatic test_fill_count();
        logic [XLEN-1:0] e;
        int nready;
        nready = 0;
        issue_valid = 1'b1;
        for (int i = 1; i < NREGS; i++) begin
            issue_rd = AW'(i);
            #1;
            if (issue_ready === 1'b1) nready++;
            tick();
        end
        idle();
        total++;
        if (nready !== NREGS - 1) begin
            bad++;
            $display("FAIL fill_ready got=%0d want=%0d", nready, NREGS - 1);
        end
        total++;
        if (busy_count !== 6'd31) begin
            bad++;
            $display("FAIL fill_count got=%0d want=31", busy_count);
        end
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        total++;
        if (issue_ready !== 1'b1) begin
            bad++;
            $display("FAIL fill_r0_ready got=%b want=1", issue_ready);
        end
        tick();
        idle();
        total++;
        if (busy_count !== 6'd31) begin
            bad++;
            $display("FAIL fill_r0_count got=%0d want=31", busy_count);
        end
        for (int i = 1; i < NREGS; i++) begin
            we = 1'b1; wa = AW'(i);
            wd = 32'h01010101 * i + 32'h1000;
            exp_q.push_back(32'h01010101 * i + 32'h1000);
            tick();
        end
        idle();
        total++;
        if (busy_count !== 6'd0) begin
            bad++;
            $display("FAIL drain_count got=%0d want=0", busy_count);
        end
        for (int i = 1; i < NREGS; i++) begin
            ra = {5'd0, AW'(i)};
            #1;
            e = exp_q.pop_front();
            total++;
            if (rd[31:0] !== e || rd_busy[0] !== 1'b0) begin
                bad++;
                $display("FAIL readback r%0d got=%h/%b want=%h/0",
                         i, rd[31:0], rd_busy[0], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nready;
        int nzero;
        issue_valid = 1'b1;
        for (int i = 2; i <= 8; i += 2) begin
            issue_rd = AW'(i);
            tick();
        end
        idle();
        total++;
        if (busy_count !== 6'd4) begin
            bad++;
            $display("FAIL mid_count got=%0d want=4", busy_count);
        end
        rst = 1'b1;
        tick();
        idle();
        total++;
        if (busy_count !== 6'd0) begin
            bad++;
            $display("FAIL mid_reset_count got=%0d want=0", busy_count);
        end
        nready = 0;
        nzero  = 0;
        for (int i = 0; i < NREGS; i++) begin
            issue_rd = AW'(i);
            ra = {AW'(i), AW'(i)};
            #1;
            if (issue_ready === 1'b1) nready++;
            if (rd === '0 && rd_busy === 2'b00) nzero++;
        end
        total++;
        if (nready !== NREGS) begin
            bad++;
            $display("FAIL mid_ready got=%0d want=%0d", nready, NREGS);
        end
        total++;
        if (nzero !== NREGS) begin
            bad++;
            $display("FAIL mid_zero got=%0d want=%0d", nzero, NREGS);
        end
    endtask

    initial begin
        idle();
        ra  = '0;
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_fill_count();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RISC-V core, successor to the fixed 2R1W file.
- Configurable data width, register count and number of read ports.
- Synchronous reset clears all architectural state.
- Adds a per-register busy scoreboard with an issue handshake, so decode can detect RAW/WAW hazards against in-flight writes from the pipeline.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; must be a power of two, at least 2
AW, 5, address width; must equal log2(NREGS)
NRD, 2, number of read ports, 1..4

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
we  input  1  writeback write enable
wa  input  AW  writeback address
wd  input  XLEN  writeback data
ra  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rd  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
rd_busy  output  NRD  port k: register ra[k] has a pending write
issue_valid  input  1  decode requests to mark a destination busy
issue_rd  input  AW  destination register to mark busy
issue_ready  output  1  issue accepted this cycle
busy_count  output  AW+1  number of registers currently busy

Behaviour:
- State: mem[0..NREGS-1] of XLEN bits, plus busy[0..NREGS-1].
- Reset, when rst is sampled high at a clock edge:
  - all mem entries go to 0 and all busy bits go to 0.
  - Takes priority over we and issue in the same cycle.
  - Reset mid-operation discards pending busy state; no write lands.
- Register 0:
  - Reads always return 0 and rd_busy is always 0.
  - Writes to 0 are ignored.
  - An issue to 0 is always ready and never sets a busy bit.
- Write: on a clock edge with we=1, wa!=0 and not in reset, mem[wa] <= wd and busy[wa] is cleared.
- Read: combinational.
  - rd[k] = mem[ra[k]], subject to bypass (see Optional Feature).
  - Out-of-range addresses cannot occur because NREGS = 2^AW.
- rd_busy[k] = busy[ra[k]] AND NOT (we AND wa==ra[k]).
  - A same-cycle writeback clears the hazard combinationally.
- Issue handshake:
  - issue_ready = (issue_rd==0) OR NOT busy[issue_rd] OR (we AND wa==issue_rd).
  - Busy is set only when issue_valid AND issue_ready; the transfer completes on that edge.
  - Decode holds issue_valid and issue_rd stable while issue_ready is 0.
  - Issue to an already-busy register is therefore stalled (WAW protection).
- Simultaneous write-clear and issue-set to the same register in one cycle: set wins, so busy stays 1 for the new in-flight instruction.
- Write to a register that is not busy: data is written and busy stays 0. This is legal and is used by CSR/load paths without issue.
- busy_count is registered, equal to the popcount of busy after each edge, and 0 after reset.
  - Per-cycle update: +1 on an accepted issue to a non-zero register, −1 on a clear of a busy register, net 0 if both hit the same register.
  - Never exceeds NREGS−1.
- Latency:
  - Write visible to a read one cycle later, or the same cycle with bypass.
  - Busy visible the cycle after issue.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. When we=1, wa!=0 and wa==ra[k], rd[k]=wd in the same cycle.
- Undefined: rd[k] always returns the stored mem value, i.e. old data during a same-cycle write. The pipeline must then insert the extra stall itself.
- rd_busy and issue_ready behave identically in both builds.

Test Plan:
- Reset then read: assert rst for 1 cycle with we=1, wa=3, wd=0xDEADBEEF → after release, all rd=0, rd_busy=0, busy_count=0, and mem[3]=0.
- Basic write/read: write wa=5, wd=0x12345678; next cycle ra[0]=5 → rd[0]=0x12345678. Write wa=0, wd=0xFFFFFFFF → rd for ra=0 is 0.
- Bypass: we=1, wa=7, wd=0xA5A5A5A5, ra[1]=7 in the same cycle → rd[1]=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value (0) without it.
- Scoreboard: issue rd=10 → next cycle rd_busy for ra=10 is 1 and busy_count=1. A second issue to 10 gives issue_ready=0 and holds. Writeback we=1, wa=10 in that cycle → issue_ready=1 and busy stays 1 (set wins). After that edge busy_count=1 and mem[10] holds wd.
- Fill/count: issue registers 1..31 on consecutive cycles → busy_count reaches 31. Issue to 0 is ready and count is unchanged. Write all 31 → count returns to 0.
- Reset mid-operation: with 4 registers busy, assert rst → busy_count=0, all issue_ready=1, all registers read 0.
